// File: rtl/iris_layer_sequencer_pkg.sv
// Shared types and constants for the Iris layer sequencer.
package iris_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ARGMAX  = 3'd4,
    ST_OUT     = 3'd5
  } seq_state_t;

  localparam int NEURON_LATENCY_DEF = 7;
  localparam int N_CLASSES_DEF      = 3;
  localparam int CLASS_W            = $clog2(N_CLASSES_DEF);

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iris_layer_sequencer_if.sv
// Sample-in / class-out valid-ready bundle between host and sequencer.
interface iris_layer_sequencer_if
  import iris_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_FEATURES = 4,
  parameter int N_CLASSES  = N_CLASSES_DEF
);
  localparam int ID_W = width_of(N_CLASSES);

  logic                               in_valid;
  logic                               in_ready;
  logic [N_FEATURES*DATA_WIDTH-1:0]   in_x;
  logic                               class_valid;
  logic                               class_ready;
  logic [ID_W-1:0]                    class_id;
  logic signed [DATA_WIDTH-1:0]       class_score;

  modport master (
    output in_valid, in_x, class_ready,
    input  in_ready, class_valid, class_id, class_score
  );

  modport slave (
    input  in_valid, in_x, class_ready,
    output in_ready, class_valid, class_id, class_score
  );
endinterface

// File: rtl/iris_layer_sequencer_argmax.sv
// Signed argmax over the captured output-layer scores; lowest index wins ties.
module iris_argmax
  import iris_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_CLASSES  = N_CLASSES_DEF,
  parameter int ID_W       = width_of(N_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [N_CLASSES*DATA_WIDTH-1:0]   scores,
  output logic [ID_W-1:0]                   class_id,
  output logic signed [DATA_WIDTH-1:0]      class_score
);
  logic [ID_W-1:0]              best_id;
  logic signed [DATA_WIDTH-1:0] best_score;
  logic signed [DATA_WIDTH-1:0] cand;
  logic [ID_W-1:0]              class_id_q, class_id_d;
  logic signed [DATA_WIDTH-1:0] class_score_q, class_score_d;

  // Strict greater-than keeps the earlier index on equal scores.
  always_comb begin
    best_id    = '0;
    best_score = $signed(scores[DATA_WIDTH-1:0]);
    cand       = '0;
    for (int i = 1; i < N_CLASSES; i++) begin
      cand = $signed(scores[i*DATA_WIDTH +: DATA_WIDTH]);
      if (cand > best_score) begin
        best_score = cand;
        best_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    if (en) begin
      class_id_d    = best_id;
      class_score_d = best_score;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_id_q    <= '0;
      class_score_q <= '0;
    end else begin
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
    end
  end

  assign class_id    = class_id_q;
  assign class_score = class_score_q;
endmodule

// File: rtl/iris_layer_sequencer.sv
// Fires the Iris neuron layers in order, then argmaxes the output layer.
// Optional `IRIS_SEQ_INFER_CNT_EN adds a 16-bit completed-result counter.
module iris_layer_sequencer
  import iris_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int N_FEATURES     = 4,
  parameter int N_LAYERS       = 3,
  parameter int N_CLASSES      = N_CLASSES_DEF,
  parameter int NEURON_LATENCY = NEURON_LATENCY_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              abort,
  iris_layer_sequencer_if.slave             bus,
  output logic [N_FEATURES*DATA_WIDTH-1:0]  x_hold,
  output logic [N_LAYERS-1:0]               layer_run,
  output logic                              neuron_rst,
  input  logic [N_CLASSES*DATA_WIDTH-1:0]   out_y,
  output logic                              busy
`ifdef IRIS_SEQ_INFER_CNT_EN
  , output logic [15:0]                     infer_cnt
`endif
);
  localparam int ID_W = width_of(N_CLASSES);
  localparam int KW   = width_of(N_LAYERS);
  localparam int CW   = width_of(NEURON_LATENCY);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RUN     = ST_RUN;
  localparam logic [2:0] S_WAIT    = ST_WAIT;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_ARGMAX  = ST_ARGMAX;
  localparam logic [2:0] S_OUT     = ST_OUT;

  localparam logic [KW-1:0] K_LAST   = KW'(N_LAYERS - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NEURON_LATENCY - 1);

  logic [2:0]                       state_q, state_d;
  logic [KW-1:0]                    k_q, k_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [N_FEATURES*DATA_WIDTH-1:0] x_hold_q, x_hold_d;
  logic [N_CLASSES*DATA_WIDTH-1:0]  score_q, score_d;
  logic                             neuron_rst_q, neuron_rst_d;
  logic                             in_ready, accept, class_valid;
  logic [ID_W-1:0]                  class_id_w;
  logic signed [DATA_WIDTH-1:0]     class_score_w;

  // Ready stays low while the neurons are being reset so no sample races them.
  assign in_ready    = (state_q == S_IDLE) & ~neuron_rst_q & ~abort & ~rst;
  assign accept      = bus.in_valid & in_ready;
  assign class_valid = (state_q == S_OUT) & ~rst;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    x_hold_d     = x_hold_q;
    score_d      = score_q;
    neuron_rst_d = rst | abort;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_hold_d = bus.in_x;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (k_q < K_LAST) begin
            k_d     = k_q + 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        score_d = out_y;
        state_d = S_ARGMAX;
      end
      S_ARGMAX: state_d = S_OUT;
      S_OUT: begin
        if (bus.class_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      x_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      x_hold_q <= x_hold_d;
    end
    neuron_rst_q <= neuron_rst_d;
    score_q      <= score_d;
  end

  iris_argmax #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_CLASSES  (N_CLASSES),
    .ID_W       (ID_W)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == S_ARGMAX),
    .scores      (score_q),
    .class_id    (class_id_w),
    .class_score (class_score_w)
  );

  assign bus.in_ready    = in_ready;
  assign bus.class_valid = class_valid;
  assign bus.class_id    = class_id_w;
  assign bus.class_score = class_score_w;
  assign x_hold          = x_hold_q;
  assign neuron_rst      = neuron_rst_q;
  assign busy            = (state_q != S_IDLE) & ~rst;
  assign layer_run       = ((state_q == S_RUN) & ~rst) ? (N_LAYERS'(1) << k_q) : '0;

`ifdef IRIS_SEQ_INFER_CNT_EN
  logic [15:0] infer_cnt_q, infer_cnt_d;

  always_comb infer_cnt_d = infer_cnt_q + 16'(class_valid & bus.class_ready);

  always_ff @(posedge clk) begin
    if (rst) infer_cnt_q <= '0;
    else     infer_cnt_q <= infer_cnt_d;
  end

  assign infer_cnt = infer_cnt_q;
`endif
endmodule
